// File: rtl/timx_cfg_seq.sv
// APB master sequencer that walks a host-loaded (op, addr, data) table to program and poll the timer.
// Optional readback verify of each WRITE is enabled by defining TIMX_CFG_SEQ_RDBK_EN.
module timx_cfg_seq #(
  parameter int TBL_DEPTH = 8,
  parameter int TBL_AW    = $clog2(TBL_DEPTH),
  parameter int POLL_MAX  = 1024
) (
  input  logic              apb_clk,
  input  logic              apb_rst_n,
  input  logic              tbl_we,
  input  logic [TBL_AW-1:0] tbl_waddr,
  input  logic [49:0]       tbl_wdata,
  input  logic              seq_start,
  input  logic              seq_abort,
  output logic              timx_psel,
  output logic              timx_penable,
  output logic              timx_pwrite,
  output logic [15:0]       timx_paddr,
  output logic [31:0]       timx_pwdata,
  input  logic [31:0]       timx_prdata,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [TBL_AW-1:0] seq_err_idx
);

  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_POLL  = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETUP, S_ACCESS, S_RB_SETUP, S_RB_ACCESS, S_DONE
  } state_t;

  logic [49:0]       tbl [TBL_DEPTH];
  state_t            state_q, state_d, adv_state;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [PCW-1:0]    poll_cnt_q, poll_cnt_d;
  logic [1:0]        op_q;
  logic [31:0]       data_q;
  logic              abort_pend_q;
  logic              err_q, err_d;
  logic [TBL_AW-1:0] err_idx_q, err_idx_d;
  logic              pwrite_q;
  logic [15:0]       paddr_q;
  logic [31:0]       pwdata_q;
  logic              load_bus, bus_write;
  logic [15:0]       bus_addr;
  logic [31:0]       bus_wdata;
  logic [49:0]       fetch_ent;
  logic [1:0]        next_op;
  logic              abort_now, last_idx;

  // Table is plain storage with no reset; host writes only land while the sequencer is idle.
  always_ff @(posedge apb_clk) begin
    if (tbl_we && state_q == S_IDLE) tbl[tbl_waddr] <= tbl_wdata;
  end

  assign fetch_ent = tbl[idx_q];
  assign next_op   = tbl[idx_q + TBL_AW'(1)][49:48];
  assign abort_now = seq_abort | abort_pend_q;
  assign last_idx  = (idx_q == TBL_AW'(TBL_DEPTH - 1));
  // Peeking at the following entry lets an END finish straight from ACCESS without a FETCH cycle.
  assign adv_state = (abort_now || last_idx || next_op == OP_END) ? S_DONE : S_FETCH;

  always_ff @(posedge apb_clk) begin
    if (!apb_rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      poll_cnt_q   <= '0;
      op_q         <= '0;
      data_q       <= '0;
      abort_pend_q <= 1'b0;
      err_q        <= 1'b0;
      err_idx_q    <= '0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      if (state_q == S_FETCH) begin
        op_q   <= fetch_ent[49:48];
        data_q <= fetch_ent[31:0];
      end
      if (load_bus) begin
        paddr_q  <= bus_addr;
        pwrite_q <= bus_write;
        pwdata_q <= bus_wdata;
      end
      if (state_q == S_IDLE || state_q == S_DONE) abort_pend_q <= 1'b0;
      else if (seq_abort)                         abort_pend_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    poll_cnt_d = poll_cnt_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    load_bus   = 1'b0;
    bus_write  = pwrite_q;
    bus_addr   = paddr_q;
    bus_wdata  = pwdata_q;
    case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          state_d    = S_FETCH;
          idx_d      = '0;
          poll_cnt_d = '0;
          err_d      = 1'b0;
          err_idx_d  = '0;
        end
      end
      S_FETCH: begin
        if (abort_now || fetch_ent[49:48] == OP_END) begin
          state_d = S_DONE;
        end else if (fetch_ent[49:48] == 2'b11) begin
          state_d   = S_DONE;
          err_d     = 1'b1;
          err_idx_d = idx_q;
        end else begin
          state_d   = S_SETUP;
          load_bus  = 1'b1;
          bus_addr  = fetch_ent[47:32];
          bus_write = (fetch_ent[49:48] == OP_WRITE);
          bus_wdata = (fetch_ent[49:48] == OP_WRITE) ? fetch_ent[31:0] : 32'h0;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (op_q != OP_POLL) begin
`ifdef TIMX_CFG_SEQ_RDBK_EN
          if (abort_now) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RB_SETUP;
            load_bus  = 1'b1;
            bus_write = 1'b0;
            bus_wdata = 32'h0;
          end
`else
          state_d = adv_state;
          if (adv_state == S_FETCH) idx_d = idx_q + TBL_AW'(1);
`endif
        end else if ((timx_prdata & data_q) != 32'h0) begin
          poll_cnt_d = '0;
          state_d    = adv_state;
          if (adv_state == S_FETCH) idx_d = idx_q + TBL_AW'(1);
        end else if (poll_cnt_q == PCW'(POLL_MAX - 1)) begin
          poll_cnt_d = '0;
          state_d    = S_DONE;
          err_d      = 1'b1;
          err_idx_d  = idx_q;
        end else begin
          poll_cnt_d = poll_cnt_q + PCW'(1);
          state_d    = abort_now ? S_DONE : S_SETUP;
        end
      end
`ifdef TIMX_CFG_SEQ_RDBK_EN
      S_RB_SETUP: state_d = S_RB_ACCESS;
      S_RB_ACCESS: begin
        if (timx_prdata != data_q) begin
          state_d   = S_DONE;
          err_d     = 1'b1;
          err_idx_d = idx_q;
        end else begin
          state_d = adv_state;
          if (adv_state == S_FETCH) idx_d = idx_q + TBL_AW'(1);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign timx_psel    = (state_q == S_SETUP) || (state_q == S_ACCESS) ||
                        (state_q == S_RB_SETUP) || (state_q == S_RB_ACCESS);
  assign timx_penable = (state_q == S_ACCESS) || (state_q == S_RB_ACCESS);
  assign timx_pwrite  = pwrite_q;
  assign timx_paddr   = paddr_q;
  assign timx_pwdata  = pwdata_q;
  assign seq_busy     = (state_q != S_IDLE);
  assign seq_done     = (state_q == S_DONE);
  assign seq_err      = err_q;
  assign seq_err_idx  = err_idx_q;

endmodule
